// File: rtl/mas_pkg.sv
// Shared definitions for the MAS8 program loader.
//   mas_state_e     : loader FSM states
//   MAS_HEADER_DEF  : default frame start byte
//   MAS_INSTR_W     : core instruction width
package mas_pkg;

  localparam logic [7:0] MAS_HEADER_DEF = 8'hA5;
  localparam int         MAS_INSTR_W    = 16;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLEAR,
    S_COUNT,
    S_HI,
    S_LO,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } mas_state_e;

  // A frame is in progress from CLEAR through CSUM; the core is in program mode.
  function automatic logic mas_is_busy(mas_state_e s);
    return s inside {S_CLEAR, S_COUNT, S_HI, S_LO, S_WRITE, S_CSUM};
  endfunction

  // States that take bytes from the link.
  function automatic logic mas_is_rx(mas_state_e s);
    return !(s inside {S_CLEAR, S_WRITE});
  endfunction

  // States in which the inter-byte idle counter runs.
  function automatic logic mas_is_timed(mas_state_e s);
    return s inside {S_COUNT, S_HI, S_LO, S_CSUM};
  endfunction

endpackage

// File: rtl/mas_byte_timeout.sv
// Inter-byte idle counter.
//   clk, rst : clock, synchronous active-high reset
//   clr      : restart the count (byte accepted / frame start)
//   en       : count this cycle
//   expired  : the counter is about to reach TIMEOUT_CYC on this edge
// TIMEOUT_CYC = 0 disables the timer (expired is tied low).
module mas_byte_timeout #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  generate
    if (TIMEOUT_CYC == 0) begin : g_off
      logic unused_ok;
      assign unused_ok = &{1'b0, clk, rst, clr, en};
      assign expired   = 1'b0;
    end else begin : g_on
      localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
      logic [CW-1:0] cnt_q;

      always_ff @(posedge clk) begin
        if (rst || clr)  cnt_q <= '0;
        else if (en)     cnt_q <= cnt_q + 1'b1;
      end

      // Fire on the edge that would make the count equal TIMEOUT_CYC, so the
      // owner changes state exactly TIMEOUT_CYC edges after the last clear.
      assign expired = en && !clr && (cnt_q == CW'(TIMEOUT_CYC - 1));
    end
  endgenerate

endmodule

// File: rtl/mas_prog_loader.sv
// MAS8 byte-stream program loader.
// Receives HEADER, N (0 = 256), 2*N instruction bytes (high byte first) and
// an 8-bit wrap-around checksum of the instruction bytes, writing each 16-bit
// word into the core through instr_in/pr/en. The core is held in reset
// (core_rstz = 0) until a frame loads with a good checksum.
//   clk, rst            : clock, synchronous active-high reset
//   rx_data/valid/ready : byte link, transfer on rx_valid & rx_ready
//   run_en              : core enable request, forwarded only once loaded
//   instr_in, pr, en    : core programming port (en is the write strobe)
//   core_rstz           : active-low core reset
//   busy, done, err     : frame in progress / loaded ok / checksum or timeout
//   dvdd, dgnd          : supply pins, no logic
module mas_prog_loader
  import mas_pkg::*;
#(
  parameter logic [7:0] HEADER      = MAS_HEADER_DEF,
  parameter int         TIMEOUT_CYC = 1000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  input  logic                   run_en,
  output logic [MAS_INSTR_W-1:0] instr_in,
  output logic                   pr,
  output logic                   en,
  output logic                   core_rstz,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  inout  wire                    dvdd,
  inout  wire                    dgnd
);

  wire unused_supply = &{1'b0, dvdd, dgnd};

  mas_state_e             state_q, state_d;
  logic [8:0]             rem_q, rem_d;
  logic [7:0]             hi_q, hi_d;
  logic [7:0]             csum_q, csum_d;
  logic [MAS_INSTR_W-1:0] instr_q, instr_d;

  logic rx_ready_q, busy_q, wr_q, done_q, err_q;
  logic acc, tmo;

  assign acc = rx_valid & rx_ready_q;

  mas_byte_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clr     (acc || (state_q == S_CLEAR)),
    .en      (mas_is_timed(state_q)),
    .expired (tmo)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    csum_d  = csum_q;
    instr_d = instr_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        // Non-header bytes are swallowed so the link never backs up.
        if (acc && rx_data == HEADER) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        csum_d  = '0;
        state_d = S_COUNT;
      end
      S_COUNT: begin
        if (acc) begin
          rem_d   = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
          state_d = S_HI;
        end else if (tmo) state_d = S_ERR;
      end
      S_HI: begin
        if (acc) begin
          hi_d    = rx_data;
          csum_d  = csum_q + rx_data;
          state_d = S_LO;
        end else if (tmo) state_d = S_ERR;
      end
      S_LO: begin
        if (acc) begin
          instr_d = {hi_q, rx_data};
          csum_d  = csum_q + rx_data;
          state_d = S_WRITE;
        end else if (tmo) state_d = S_ERR;
      end
      S_WRITE: begin
        rem_d   = rem_q - 9'd1;
        state_d = (rem_d == 9'd0) ? S_CSUM : S_HI;
      end
      S_CSUM: begin
        if (acc)      state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
        else if (tmo) state_d = S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they move on the same
  // edge as the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      hi_q       <= '0;
      csum_q     <= '0;
      instr_q    <= '0;
      rx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      wr_q       <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      hi_q       <= hi_d;
      csum_q     <= csum_d;
      instr_q    <= instr_d;
      rx_ready_q <= mas_is_rx(state_d);
      busy_q     <= mas_is_busy(state_d);
      wr_q       <= (state_d == S_WRITE);
      done_q     <= (state_d == S_DONE);
      err_q      <= (state_d == S_ERR);
    end
  end

  assign rx_ready  = rx_ready_q;
  assign instr_in  = instr_q;
  assign busy      = busy_q;
  assign pr        = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  // Released only after a good load; ERR and any frame in progress keep the
  // core (and its memory) in reset.
  assign core_rstz = done_q;
  assign en        = wr_q | (done_q & run_en);

endmodule
